ula_seq_nibble: RTL

// - Multi-cycle WIDTH-bit ALU sequencer placed directly upstream of one ula_74181 slice.
// - Accepts a full-width operation over a valid/ready handshake and feeds the slice one nibble per cycle, LSB first.
// - Chains the slice carry through a register between nibbles and assembles the WIDTH-bit result and flags.
// - Presents the result over a valid/ready handshake to the datapath.

---
 rtl/ula_pkg.sv | 22 ++
 rtl/ula_74181.sv | 35 +++
 rtl/ula_seq_nibble.sv | 119 +++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the 74181-based ALU sequencer: FSM state encoding
// and the function-select codes the datapath uses most often.
package ula_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ula_seq_state_t;

    localparam int NIB_W = 4;

    // Arithmetic-mode selects (m = 0)
    localparam logic [3:0] S_SUB_MINUS1 = 4'b0110;
    localparam logic [3:0] S_ADD        = 4'b1001;

    // Logic-mode selects (m = 1)
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_OR  = 4'b1110;

endpackage

// File: rtl/ula_74181.sv
// Combinational 4-bit 74181 ALU slice, active-high data. Carry in and carry
// out are active-low, as on the original part (c_in = 1 means no carry).
module ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] half;
    logic [4:0] c;

    // Arithmetic result is p plus g (g is always a subset of p), so the
    // pair gives a direct propagate/generate carry chain.
    always_comb begin
        p    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        g    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        half = p ^ g;
        c    = '0;
        c[0] = ~c_in;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        f      = m ? ~half : (half ^ c[3:0]);
        c_out  = ~c[4];
        a_eq_b = &f;
    end

endmodule

// File: rtl/ula_seq_nibble.sv
// Multi-cycle WIDTH-bit ALU sequencer: feeds one 74181 slice a nibble per
// cycle, LSB first, chaining the carry through a register between nibbles.
module ula_seq_nibble
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             a_eq_b,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    ula_seq_state_t state;
    ula_seq_state_t state_nxt;

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       s_r;
    logic             m_r;
    logic             cy;
    logic [WIDTH-1:0] f_r;
    logic             eq_acc;

    logic             accept;
    logic             last;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_f;
    logic             slice_c_out;
    logic             slice_eq;

    assign accept = (state == ST_IDLE) && in_valid;
    assign last   = (idx == LAST_IDX);

    // Nibble select by shifting keeps the index arithmetic width-clean for any WIDTH.
    assign slice_a = 4'(a_r >> {idx, 2'b00});
    assign slice_b = 4'(b_r >> {idx, 2'b00});

    ula_74181 u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .s      (s_r),
        .m      (m_r),
        .c_in   (cy),
        .f      (slice_f),
        .c_out  (slice_c_out),
        .a_eq_b (slice_eq)
    );

    always_comb begin
        // NOTE: state_nxt is defaulted before the case so every path assigns it and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: registers update with <= so every flop samples pre-edge values; = here would race between blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            cy     <= 1'b0;
            f_r    <= '0;
            eq_acc <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx    <= '0;
                cy     <= c_in;
                f_r    <= '0;
                eq_acc <= 1'b1;
            end else if (state == ST_RUN) begin
                f_r    <= f_r | (WIDTH'(slice_f) << {idx, 2'b00});
                cy     <= slice_c_out;
                eq_acc <= eq_acc & slice_eq;
                idx    <= idx + 1'b1;
            end
        end
    end

    // NOTE: operand holding registers carry no reset; they are only read in RUN, which always follows a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b;
            s_r <= s;
            m_r <= m;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign f         = f_r;
    assign c_out     = cy;
    assign a_eq_b    = eq_acc;
    assign zero      = (f_r == '0);

endmodule
